// File: rtl/dispatch_imm_alloc_pkg.sv
// Shared types for the dispatch immediate-allocation stage.
package dispatch_imm_alloc_pkg;

    localparam int WIDTH    = 4;
    localparam int DQ_DEPTH = 30;
    localparam int DQW      = $clog2(DQ_DEPTH);

    typedef logic [63:0]    imm_t;
    typedef logic [DQW-1:0] dq_idx_t;

    // Payload carried alongside each lane; never inspected by this stage.
    typedef struct packed {
        logic [7:0] op;
        logic [5:0] rd;
    } uop_t;

    typedef enum logic {
        RUN     = 1'b0,
        RELEASE = 1'b1
    } state_e;

endpackage

// File: rtl/dispatch_imm_alloc.sv
// Dispatch-side allocation stage in front of the imm/pc data queue.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// RUN     | accept rename groups, enqueue immediates, register toward issue
// RELEASE | hand dqIdx of squashed, never-issued entries back to the data queue
module dispatch_imm_alloc
    import dispatch_imm_alloc_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_squash,
    input  logic [WIDTH-1:0]           i_in_vld,
    input  logic [WIDTH-1:0]           i_in_need_imm,
    input  imm_t    [WIDTH-1:0]        i_in_imm,
    input  uop_t    [WIDTH-1:0]        i_in_uop,
    output logic                       o_in_rdy,
    output logic [WIDTH-1:0]           o_dq_enq_req,
    output imm_t    [WIDTH-1:0]        o_dq_enq_data,
    input  logic                       i_dq_can_enq,
    input  dq_idx_t [WIDTH-1:0]        i_dq_alloc_id,
    output logic [WIDTH-1:0]           o_out_vld,
    output uop_t    [WIDTH-1:0]        o_out_uop,
    output logic [WIDTH-1:0]           o_out_has_imm,
    output dq_idx_t [WIDTH-1:0]        o_out_dqIdx,
    input  logic                       i_out_rdy,
    output logic [WIDTH-1:0]           o_rel_vld,
    output dq_idx_t [WIDTH-1:0]        o_rel_dqIdx,
    input  logic                       i_rel_rdy,
    output logic [31:0]                o_stall_cnt
);

    state_e                state_q, state_d;
    logic [WIDTH-1:0]      out_vld_q, out_vld_d;
    logic [WIDTH-1:0]      has_imm_q, has_imm_d;
    uop_t    [WIDTH-1:0]   out_uop_q, out_uop_d;
    dq_idx_t [WIDTH-1:0]   dq_idx_q, dq_idx_d;
    logic [WIDTH-1:0]      rel_vld_q, rel_vld_d;
    dq_idx_t [WIDTH-1:0]   rel_idx_q, rel_idx_d;
    logic [31:0]           stall_cnt_q, stall_cnt_d;

    logic             out_free;
    logic             need_dq;
    logic             accept;
    logic [WIDTH-1:0] squash_imm;

    // Acceptance: i_dq_can_enq is a free-count indication, so it never depends on o_dq_enq_req.
    always_comb begin
        out_free   = ~|out_vld_q | i_out_rdy;
        need_dq    = |(i_in_vld & i_in_need_imm);
        accept     = (state_q == RUN) & ~i_squash & |i_in_vld & out_free
                   & (~need_dq | i_dq_can_enq);
        squash_imm = out_vld_q & has_imm_q;
    end

    // State register and all stage registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            out_vld_q   <= '0;
            has_imm_q   <= '0;
            out_uop_q   <= '0;
            dq_idx_q    <= '0;
            rel_vld_q   <= '0;
            rel_idx_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            out_vld_q   <= out_vld_d;
            has_imm_q   <= has_imm_d;
            out_uop_q   <= out_uop_d;
            dq_idx_q    <= dq_idx_d;
            rel_vld_q   <= rel_vld_d;
            rel_idx_q   <= rel_idx_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Next-state: group capture, squash handling and release handshake.
    always_comb begin
        state_d     = state_q;
        out_vld_d   = out_vld_q;
        has_imm_d   = has_imm_q;
        out_uop_d   = out_uop_q;
        dq_idx_d    = dq_idx_q;
        rel_vld_d   = rel_vld_q;
        rel_idx_d   = rel_idx_q;
        stall_cnt_d = stall_cnt_q;

        case (state_q)
            RUN: begin
                if (i_squash) begin
                    out_vld_d = '0;
                    if (|squash_imm) begin
                        state_d   = RELEASE;
                        rel_vld_d = squash_imm;
                        rel_idx_d = dq_idx_q;
                    end
                end else if (accept) begin
                    out_vld_d = i_in_vld;
                    has_imm_d = i_in_vld & i_in_need_imm;
                    out_uop_d = i_in_uop;
                    dq_idx_d  = i_dq_alloc_id;
                end else if (i_out_rdy) begin
                    out_vld_d = '0;
                end
            end
            RELEASE: begin
                // A squash here leaves the latched set alone; only the handshake exits.
                if (i_rel_rdy) begin
                    state_d   = RUN;
                    rel_vld_d = '0;
                end
            end
            default: state_d = RUN;
        endcase

        if (|i_in_vld && !accept && !i_squash && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Output drive; a squash cycle never hands a group to issue.
    always_comb begin
        o_in_rdy      = accept;
        o_dq_enq_req  = accept ? (i_in_vld & i_in_need_imm) : '0;
        o_dq_enq_data = i_in_imm;
        o_out_vld     = (state_q == RUN) ? (out_vld_q & {WIDTH{~i_squash}}) : '0;
        o_out_uop     = out_uop_q;
        o_out_has_imm = has_imm_q & out_vld_q;
        o_out_dqIdx   = dq_idx_q;
        o_rel_vld     = (state_q == RELEASE) ? rel_vld_q : '0;
        o_rel_dqIdx   = rel_idx_q;
        o_stall_cnt   = stall_cnt_q;
    end

endmodule
